paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter NUM_PADDLES, default 2: number of independent paddle channels (1..8).
REQ-002 SHALL have parameter Y_WIDTH, default 11: width of every vertical coordinate.
REQ-003 SHALL have parameter SHEIGHT, default 480: active screen height in lines.
REQ-004 SHALL have parameter PADDLE_HEIGHT, default 25: paddle half-height; paddle spans paddle_y ± PADDLE_HEIGHT.
REQ-005 SHALL have parameter STEP, default 8: lines moved per valid encoder step.
REQ-006 SHALL have parameter AUTO_STEP, default 1: lines moved per frame in autopilot.
REQ-007 SHALL have port clk, input, 1: the single system (pixel) clock; one clock, all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port quad_a, input, NUM_PADDLES: encoder A phase per channel; asynchronous.
REQ-010 SHALL have port quad_b, input, NUM_PADDLES: encoder B phase per channel; asynchronous.
REQ-011 SHALL have port auto_en, input, NUM_PADDLES: 1 = channel in autopilot, 0 = manual.
REQ-012 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-013 SHALL have port ball_y, input, Y_WIDTH: ball top line; autopilot target.
REQ-014 SHALL have port paddle_y, output, NUM_PADDLES*Y_WIDTH: paddle centre per channel; channel i occupies bits [i*Y_WIDTH +: Y_WIDTH].
REQ-015 SHALL have port moved, output, NUM_PADDLES: one-cycle pulse when that channel's paddle_y changed value.
REQ-016 SHALL have port err_cnt, output, NUM_PADDLES*8: per-channel saturating count of illegal encoder transitions.

Function
REQ-017 SHALL pass each quad_a/quad_b bit through a 2-flop synchronizer, then hold a "previous" register of the synchronized pair.
REQ-018 SHALL decode Gray sequence 00→01→11→10→00 as +1 (paddle down, y increases) and the reverse as −1.
REQ-019 SHALL treat no change as no step, and a simultaneous change of both phases as illegal: no step, err_cnt +1, saturating at 255.
REQ-020 SHALL update paddle_y on the 3rd rising clk edge after the pin change is first sampled (2 sync flops + 1 update).
REQ-021 SHALL define Y_MIN = PADDLE_HEIGHT and Y_MAX = SHEIGHT−1−PADDLE_HEIGHT; paddle_y SHALL never leave [Y_MIN, Y_MAX].
REQ-022 SHALL saturate at the bounds rather than skip the move: a step that would cross a bound lands exactly on the bound.
REQ-023 SHALL ignore encoder steps for a channel while its auto_en = 1; the previous-state register still tracks, so returning to manual produces no spurious step.
REQ-024 SHALL, in autopilot, act only on a cycle with frame_tick = 1: paddle_y < ball_y → +AUTO_STEP; paddle_y > ball_y → −AUTO_STEP; equal → hold; all moves clamped per REQ-022.
REQ-025 SHALL compute all bound arithmetic at Y_WIDTH+1 bits so the subtraction near 0 cannot wrap.
REQ-026 SHALL assert moved[i] for exactly one cycle, coincident with the new paddle_y value, only if the value actually changed; a move clamped to the same value gives no pulse.
REQ-027 SHALL keep channels fully independent: simultaneous events on different channels are all applied in the same cycle.

Reset
REQ-028 SHALL, while reset = 1 at a clk edge, set every paddle_y to SHEIGHT/2, moved to 0, err_cnt to 0, and the synchronizers and previous-state registers to 00.
REQ-029 SHALL let reset asserted mid-operation override any concurrent step or frame_tick in that cycle.
REQ-030 SHALL treat the first synchronized non-00 input after reset as an ordinary transition from 00.

Structure
REQ-031 SHALL place SHEIGHT, Y_WIDTH, PADDLE_HEIGHT and the step defaults in a shared package pong_pkg, also used by the ball/score logic.
REQ-032 SHALL implement synchronizer, previous-state register and Gray decode in one sub-module quad_decoder (outputs step_valid, step_dir, illegal), instantiated NUM_PADDLES times in a generate loop.

Verification
REQ-033 SHALL cover: after reset, drive channel 0 through 00→01→11→10→00 at 10-clk spacing → paddle_y[0] 240→272, four moved pulses.
REQ-034 SHALL cover: from 240, 30 reverse steps → paddle_y stops at 25, the last step clamps from 32 to 25, and no moved pulse once it is held at 25.
REQ-035 SHALL cover: toggle A and B together on channel 1 three times → err_cnt[1] = 3, paddle_y[1] unchanged at 240.
REQ-036 SHALL cover: auto_en[0] = 1, ball_y = 250, 12 frame_ticks → paddle_y[0] 240→250 then holds; encoder steps applied during this are ignored.
REQ-037 SHALL cover: reset asserted in the same cycle as a valid step and a frame_tick → paddle_y = 240, moved = 0 next cycle.
REQ-038 SHALL cover: NUM_PADDLES = 4, all channels step +1 in the same cycle → all four paddle_y = 248 together.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the pong datapath (paddles, ball, score) plus the
// quadrature Gray-position helper used by the encoder decoders.
package pong_pkg;

  localparam int SHEIGHT       = 480;
  localparam int Y_WIDTH       = 11;
  localparam int PADDLE_HEIGHT = 25;
  localparam int STEP          = 8;
  localparam int AUTO_STEP     = 1;

  // Position of an {a,b} phase pair along the sequence 00 -> 01 -> 11 -> 10.
  // The difference of two positions (mod 4) gives +1, -1 or an illegal jump.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// One quadrature channel: 2-flop synchronizer on the raw phases, a
// previous-state register, and combinational Gray decode of the pair.
module quad_decoder
  import pong_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic step_valid,
  output logic step_dir,
  output logic illegal
);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] prev;
  logic [1:0] pos_diff;

  // Synchronize the asynchronous phases and remember the last synchronized pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      prev  <= 2'b00;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Diff of 1 is a forward step, 3 a backward step, 2 means both phases flipped.
  always_comb begin
    pos_diff   = gray_pos(sync2) - gray_pos(prev);
    step_valid = (pos_diff == 2'd1) || (pos_diff == 2'd3);
    step_dir   = (pos_diff == 2'd1);
    illegal    = (pos_diff == 2'd2);
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: per channel, a quadrature encoder moves the
// paddle in manual mode, or the paddle tracks ball_y once per frame in
// autopilot. Positions are clamped to keep the whole paddle on screen.
module paddle_ctrl #(
  parameter int NUM_PADDLES   = 2,
  parameter int Y_WIDTH       = pong_pkg::Y_WIDTH,
  parameter int SHEIGHT       = pong_pkg::SHEIGHT,
  parameter int PADDLE_HEIGHT = pong_pkg::PADDLE_HEIGHT,
  parameter int STEP          = pong_pkg::STEP,
  parameter int AUTO_STEP     = pong_pkg::AUTO_STEP
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PADDLES-1:0]         quad_a,
  input  logic [NUM_PADDLES-1:0]         quad_b,
  input  logic [NUM_PADDLES-1:0]         auto_en,
  input  logic                           frame_tick,
  input  logic [Y_WIDTH-1:0]             ball_y,
  output logic [NUM_PADDLES*Y_WIDTH-1:0] paddle_y,
  output logic [NUM_PADDLES-1:0]         moved,
  output logic [NUM_PADDLES*8-1:0]       err_cnt
);

  // Bounds are held one bit wider than a coordinate so y - step cannot wrap.
  localparam logic [Y_WIDTH:0]   Y_MIN_W   = (Y_WIDTH+1)'(PADDLE_HEIGHT);
  localparam logic [Y_WIDTH:0]   Y_MAX_W   = (Y_WIDTH+1)'(SHEIGHT - 1 - PADDLE_HEIGHT);
  localparam logic [Y_WIDTH:0]   STEP_W    = (Y_WIDTH+1)'(STEP);
  localparam logic [Y_WIDTH:0]   AUTO_W    = (Y_WIDTH+1)'(AUTO_STEP);
  localparam logic [Y_WIDTH-1:0] Y_RESET   = Y_WIDTH'(SHEIGHT / 2);

  function automatic logic [Y_WIDTH-1:0] move_up(input logic [Y_WIDTH-1:0] y,
                                                 input logic [Y_WIDTH:0]   amt);
    logic [Y_WIDTH:0] sum;
    sum = {1'b0, y} + amt;
    return (sum > Y_MAX_W) ? Y_MAX_W[Y_WIDTH-1:0] : sum[Y_WIDTH-1:0];
  endfunction

  function automatic logic [Y_WIDTH-1:0] move_dn(input logic [Y_WIDTH-1:0] y,
                                                 input logic [Y_WIDTH:0]   amt);
    logic [Y_WIDTH:0] diff;
    diff = {1'b0, y} - amt;
    return ({1'b0, y} < (Y_MIN_W + amt)) ? Y_MIN_W[Y_WIDTH-1:0] : diff[Y_WIDTH-1:0];
  endfunction

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
    logic               step_valid;
    logic               step_dir;
    logic               illegal;
    logic [Y_WIDTH-1:0] y_q;
    logic [Y_WIDTH-1:0] y_nxt;
    logic               moved_q;
    logic [7:0]         err_q;

    quad_decoder u_dec (
      .clk        (clk),
      .reset      (reset),
      .a          (quad_a[i]),
      .b          (quad_b[i]),
      .step_valid (step_valid),
      .step_dir   (step_dir),
      .illegal    (illegal)
    );

    // Next position: autopilot acts on frame_tick only, manual on encoder steps.
    always_comb begin
      y_nxt = y_q;
      if (auto_en[i]) begin
        if (frame_tick) begin
          if (y_q < ball_y)      y_nxt = move_up(y_q, AUTO_W);
          else if (y_q > ball_y) y_nxt = move_dn(y_q, AUTO_W);
        end
      end else if (step_valid) begin
        y_nxt = step_dir ? move_up(y_q, STEP_W) : move_dn(y_q, STEP_W);
      end
    end

    // Register position, change pulse and saturating illegal-transition count.
    always_ff @(posedge clk) begin
      if (reset) begin
        y_q     <= Y_RESET;
        moved_q <= 1'b0;
        err_q   <= 8'd0;
      end else begin
        y_q     <= y_nxt;
        moved_q <= (y_nxt != y_q);
        if (illegal && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      end
    end

    assign paddle_y[i*Y_WIDTH +: Y_WIDTH] = y_q;
    assign moved[i]                       = moved_q;
    assign err_cnt[i*8 +: 8]              = err_q;
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl with four channels. Expected paddle moves are pushed
// to a queue as stimulus is driven; a negedge monitor pops one entry per
// moved pulse and compares channel and position.
module tb_paddle_ctrl;

  localparam int NP    = 4;
  localparam int YW    = 11;
  localparam int Y_MIN = 25;
  localparam int Y_MAX = 454;
  localparam int Y_MID = 240;
  localparam int STEP  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    quad_a;
  logic [NP-1:0]    quad_b;
  logic [NP-1:0]    auto_en;
  logic             frame_tick;
  logic [YW-1:0]    ball_y;
  logic [NP*YW-1:0] paddle_y;
  logic [NP-1:0]    moved;
  logic [NP*8-1:0]  err_cnt;

  paddle_ctrl #(.NUM_PADDLES(NP)) dut (
    .clk        (clk),
    .reset      (reset),
    .quad_a     (quad_a),
    .quad_b     (quad_b),
    .auto_en    (auto_en),
    .frame_tick (frame_tick),
    .ball_y     (ball_y),
    .paddle_y   (paddle_y),
    .moved      (moved),
    .err_cnt    (err_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          pos[NP];
  int          y_m[NP];
  int          mv_cnt[NP];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [YW-1:0] y_of(input int c);
    return paddle_y[c*YW +: YW];
  endfunction

  function automatic logic [1:0] phase(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Reference model of one clamped move; queues the result only if it changes.
  task automatic model_move(input int c, input bit dir, input int amt);
    int n;
    if (dir) n = (y_m[c] + amt > Y_MAX) ? Y_MAX : y_m[c] + amt;
    else     n = (y_m[c] < Y_MIN + amt) ? Y_MIN : y_m[c] - amt;
    if (n != y_m[c]) exp_q.push_back({5'(c), 11'(n)});
    y_m[c] = n;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    for (int c = 0; c < NP; c++) begin
      if (moved[c]) begin
        mv_cnt[c]++;
        if (exp_q.size() == 0) begin
          check($sformatf("spurious_moved_ch%0d", c), 32'(moved[c]), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("move_ch%0d", c), 32'({5'(c), y_of(c)}), 32'(e));
        end
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_pins();
    for (int c = 0; c < NP; c++) {quad_a[c], quad_b[c]} = phase(pos[c]);
  endtask

  task automatic enc_step(input int c, input bit dir, input int gap);
    pos[c] = dir ? (pos[c] + 1) % 4 : (pos[c] + 3) % 4;
    drive_pins();
    if (!auto_en[c]) model_move(c, dir, STEP);
    repeat (gap) @(negedge clk);
  endtask

  task automatic tick(input int gap);
    frame_tick = 1'b1;
    for (int c = 0; c < NP; c++) begin
      if (auto_en[c]) begin
        if (y_m[c] < int'(ball_y))      model_move(c, 1'b1, 1);
        else if (y_m[c] > int'(ball_y)) model_move(c, 1'b0, 1);
      end
    end
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int c = 0; c < NP; c++) begin
      y_m[c]    = Y_MID;
      mv_cnt[c] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Return every channel's pins to 00 with backward steps, then drain.
  task automatic park_all();
    for (int c = 0; c < NP; c++)
      while (pos[c] != 0) enc_step(c, 1'b0, 4);
    repeat (6) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset      = 1'b1;
    quad_a     = '0;
    quad_b     = '0;
    auto_en    = '0;
    frame_tick = 1'b0;
    ball_y     = '0;
    for (int c = 0; c < NP; c++) pos[c] = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state on every channel
    for (int c = 0; c < NP; c++) begin
      check($sformatf("rst_y_ch%0d", c), 32'(y_of(c)), 32'(Y_MID));
      check($sformatf("rst_moved_ch%0d", c), 32'(moved[c]), 32'd0);
      check($sformatf("rst_err_ch%0d", c), 32'(err_cnt[c*8 +: 8]), 32'd0);
    end

    // Forward Gray cycle on channel 0, with latency of the first step
    enc_step(0, 1'b1, 0);
    repeat (2) @(negedge clk);
    check("lat_before", 32'(y_of(0)), 32'(Y_MID));
    @(negedge clk);
    check("lat_third_edge", 32'(y_of(0)), 32'(Y_MID + STEP));
    repeat (7) @(negedge clk);
    for (int k = 0; k < 3; k++) enc_step(0, 1'b1, 10);
    check("fwd_cycle_y", 32'(y_of(0)), 32'd272);
    check("fwd_cycle_pulses", 32'(mv_cnt[0]), 32'd4);

    // 30 backward steps from the middle: clamps 32 -> 25 and then holds
    park_all();
    do_reset();
    for (int k = 0; k < 30; k++) enc_step(0, 1'b0, 4);
    repeat (5) @(negedge clk);
    check("low_clamp_y", 32'(y_of(0)), 32'(Y_MIN));
    check("low_clamp_pulses", 32'(mv_cnt[0]), 32'd27);

    // Illegal double transitions on channel 1
    park_all();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pos[1] = (pos[1] + 2) % 4;
      drive_pins();
      repeat (6) @(negedge clk);
    end
    check("illegal_err1", 32'(err_cnt[15:8]), 32'd3);
    check("illegal_y1", 32'(y_of(1)), 32'(Y_MID));
    check("illegal_err0", 32'(err_cnt[7:0]), 32'd0);

    // Autopilot on channel 0 toward ball_y = 250, encoder ignored meanwhile
    auto_en[0] = 1'b1;
    ball_y     = 11'd250;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      tick(4);
      if (k == 3 || k == 7) enc_step(0, 1'b1, 3);
    end
    repeat (4) @(negedge clk);
    check("auto_y", 32'(y_of(0)), 32'd250);
    auto_en[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("manual_return_y", 32'(y_of(0)), 32'd250);
    enc_step(0, 1'b1, 6);
    check("manual_after_auto", 32'(y_of(0)), 32'd258);

    // Reset coinciding with a valid step and a frame_tick
    park_all();
    auto_en[1] = 1'b1;
    ball_y     = 11'd250;
    pos[0]     = 1;
    drive_pins();
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    frame_tick = 1'b0;
    auto_en[1] = 1'b0;
    model_reset();
    check("rst_override_y0", 32'(y_of(0)), 32'(Y_MID));
    check("rst_override_y1", 32'(y_of(1)), 32'(Y_MID));
    check("rst_override_moved", 32'(moved), 32'd0);
    // Pins still at 01: first synchronized sample is a step from 00
    model_move(0, 1'b1, STEP);
    repeat (6) @(negedge clk);
    check("post_reset_step", 32'(y_of(0)), 32'(Y_MID + STEP));

    // All four channels step in the same cycle
    park_all();
    do_reset();
    for (int c = 0; c < NP; c++) pos[c] = 1;
    drive_pins();
    for (int c = 0; c < NP; c++) model_move(c, 1'b1, STEP);
    repeat (3) @(negedge clk);
    check("all_moved", 32'(moved), 32'hF);
    for (int c = 0; c < NP; c++)
      check($sformatf("all_y_ch%0d", c), 32'(y_of(c)), 32'(Y_MID + STEP));
    repeat (4) @(negedge clk);

    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
